ahb5_slave_mem: RTL

- Synthesizable AHB5 subordinate backed by a register-array memory.
- Acts as the responding end for the AHB5 master VIP: the DUT-side target the master driver talks to, replacing the dummy slave driver.
- Supports programmable wait states, byte/halfword/word transfers, and the two-cycle ERROR response.
- Sits behind the AHB5 interface; HSEL comes from an external decoder and HREADY from the bus mux.

---
 rtl/ahb5_pkg.sv | 27 ++
 rtl/ahb5_byte_lane_decode.sv | 29 ++
 rtl/ahb5_slave_mem.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ahb5_pkg.sv
// Shared AHB5 types: transfer/size encodings, response codes and subordinate states.
package ahb5_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef logic [2:0] hsize_t;
  localparam hsize_t HSIZE_BYTE = 3'b000;
  localparam hsize_t HSIZE_HALF = 3'b001;
  localparam hsize_t HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } slv_state_t;

endpackage

// File: rtl/ahb5_byte_lane_decode.sv
// Little-endian byte strobe and alignment check for one transfer of size hsize at addr.
module ahb5_byte_lane_decode
  import ahb5_pkg::*;
(
  input  logic [1:0] addr,
  input  hsize_t     hsize,
  output logic [3:0] strb,
  output logic       misalign
);

  always_comb begin
    strb     = 4'b0000;
    misalign = 1'b0;
    case (hsize)
      HSIZE_BYTE: strb = 4'b0001 << addr;
      HSIZE_HALF: begin
        strb     = addr[1] ? 4'b1100 : 4'b0011;
        misalign = addr[0];
      end
      HSIZE_WORD: begin
        strb     = 4'b1111;
        misalign = |addr;
      end
      // oversized transfers are rejected by the caller; no lanes enabled
      default: ;
    endcase
  end

endmodule

// File: rtl/ahb5_slave_mem.sv
// AHB5 subordinate backed by a word array, with programmable wait states and
// the two-cycle ERROR response for out-of-range, oversized or misaligned transfers.
//
// state | meaning
// IDLE  | no data phase pending; zero-wait OKAY
// WAIT  | OKAY data phase stalled, HREADYOUT low while the counter runs
// DONE  | last OKAY data-phase cycle; write commits at its closing edge
// ERR1  | first ERROR cycle, HREADYOUT low
// ERR2  | second ERROR cycle, HREADYOUT high
module ahb5_slave_mem
  import ahb5_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  slv_state_t            state, state_nxt;
  logic [3:0]            wait_cnt, wait_cnt_nxt;
  logic                  wr_q;
  logic [IDX_W-1:0]      idx_q;
  logic [3:0]            strb_q;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  htrans_t               trans;
  logic                  accept;
  logic                  addr_err;
  logic                  misalign;
  logic [3:0]            strb;
  logic [ADDR_WIDTH-1:0] offset;

  // burst type and protection carry no meaning for a flat memory
  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT};

  assign trans  = htrans_t'(HTRANS);
  assign accept = HSEL && HREADY && (trans == HTRANS_NONSEQ || trans == HTRANS_SEQ);
  assign offset = HADDR - BASE_ADDR;

  ahb5_byte_lane_decode u_lane_decode (
    .addr     (HADDR[1:0]),
    .hsize    (HSIZE),
    .strb     (strb),
    .misalign (misalign)
  );

  assign addr_err = (HADDR < BASE_ADDR)
                 || ((offset >> 2) >= ADDR_WIDTH'(MEM_DEPTH))
                 || (HSIZE > HSIZE_WORD)
                 || misalign;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      wr_q     <= 1'b0;
      idx_q    <= '0;
      strb_q   <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (accept && state_nxt != state_nxt.first() && (state == ST_IDLE || state == ST_DONE || state == ST_ERR2)) begin
        wr_q   <= HWRITE;
        idx_q  <= offset[IDX_W+1:2];
        strb_q <= strb;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    HREADYOUT    = 1'b1;
    HRESP        = HRESP_OKAY;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (state == ST_ERR2) HRESP = HRESP_ERROR;
        state_nxt = ST_IDLE;
        if (accept) begin
          if (addr_err) begin
            state_nxt = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = 4'(WAIT_STATES - 1);
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (wait_cnt == 4'd0) state_nxt = ST_DONE;
        else                  wait_cnt_nxt = wait_cnt - 4'd1;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_nxt = ST_ERR2;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Array is deliberately not reset; a reset mid-phase leaves state != DONE so the write drops.
  always_ff @(posedge HCLK) begin
    if (!HRESET && state == ST_DONE && wr_q) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_q[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HRDATA = ((state == ST_WAIT || state == ST_DONE) && !wr_q) ? mem[idx_q] : '0;

endmodule
